// File: rtl/pd_pluse_timer_mc_pkg.sv
// Shared constants for the multi-channel pulse-duration timer: overflow modes
// and the default channel count / counter width.
package pd_pluse_timer_mc_pkg;

  localparam int PD_MODE_WRAP     = 0;
  localparam int PD_MODE_SAT      = 1;
  localparam int PD_DEFAULT_WIDTH = 16;
  localparam int PD_DEFAULT_CH    = 4;

endpackage

// File: rtl/pd_pluse_timer_ch.sv
// One pulse-duration channel: counts gated dds edges, captures the duration on
// every gate fall and raises a one-cycle hit when the count reaches thresh.
module pd_pluse_timer_ch
  import pd_pluse_timer_mc_pkg::*;
#(
  parameter int WIDTH    = PD_DEFAULT_WIDTH,
  parameter int SAT_MODE = PD_MODE_SAT
) (
  input  logic             dds,
  input  logic             rst,
  input  logic             gate,
  input  logic [WIDTH-1:0] thresh,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             hit,
  output logic [WIDTH-1:0] cap,
  output logic             cap_ovf,
  output logic             cap_valid
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             hit_q, hit_d;
  logic [WIDTH-1:0] cap_q;
  logic             cap_ovf_q;
  logic             cap_valid_q;
  logic             gate_d_q;
  logic             at_max;
  logic             fall;

  assign at_max = (count_q == {WIDTH{1'b1}});
  assign fall   = gate_d_q & ~gate;

  // A dropped gate clears the window; a saturated hold leaves count unchanged,
  // which is what keeps hit from re-firing while parked at max.
  always_comb begin
    count_d = '0;
    ovf_d   = 1'b0;
    hit_d   = 1'b0;
    if (gate) begin
      if (at_max) begin
        count_d = (SAT_MODE != PD_MODE_WRAP) ? count_q : '0;
        ovf_d   = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
        ovf_d   = ovf_q;
      end
      hit_d = (thresh != '0) && (count_d == thresh) && (count_d != count_q);
    end
  end

  always_ff @(posedge dds) begin
    if (rst) begin
      count_q     <= '0;
      ovf_q       <= 1'b0;
      hit_q       <= 1'b0;
      cap_q       <= '0;
      cap_ovf_q   <= 1'b0;
      cap_valid_q <= 1'b0;
      gate_d_q    <= 1'b0;
    end else begin
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      hit_q       <= hit_d;
      gate_d_q    <= gate;
      cap_valid_q <= fall;
      if (fall) begin
        cap_q     <= count_q;
        cap_ovf_q <= ovf_q;
      end
    end
  end

  assign count     = count_q;
  assign ovf       = ovf_q;
  assign hit       = hit_q;
  assign cap       = cap_q;
  assign cap_ovf   = cap_ovf_q;
  assign cap_valid = cap_valid_q;

endmodule

// File: rtl/pd_pluse_timer_mc.sv
// Multi-channel pulse-duration timer: forms each channel gate from its two
// qualifiers and packs CH independent channel timers into flat vectors.
module pd_pluse_timer_mc
  import pd_pluse_timer_mc_pkg::*;
#(
  parameter int CH       = PD_DEFAULT_CH,
  parameter int WIDTH    = PD_DEFAULT_WIDTH,
  parameter int SAT_MODE = PD_MODE_SAT
) (
  input  logic                dds,
  input  logic                rst,
  input  logic [CH-1:0]       pluse_start,
  input  logic [CH-1:0]       stateover,
  input  logic [WIDTH-1:0]    thresh,
  output logic [CH*WIDTH-1:0] count,
  output logic [CH-1:0]       ovf,
  output logic [CH-1:0]       hit,
  output logic [CH*WIDTH-1:0] cap,
  output logic [CH-1:0]       cap_ovf,
  output logic [CH-1:0]       cap_valid
);

  logic [CH-1:0] gate;

  assign gate = pluse_start & stateover;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    pd_pluse_timer_ch #(
      .WIDTH   (WIDTH),
      .SAT_MODE(SAT_MODE)
    ) u_ch (
      .dds      (dds),
      .rst      (rst),
      .gate     (gate[i]),
      .thresh   (thresh),
      .count    (count[i*WIDTH +: WIDTH]),
      .ovf      (ovf[i]),
      .hit      (hit[i]),
      .cap      (cap[i*WIDTH +: WIDTH]),
      .cap_ovf  (cap_ovf[i]),
      .cap_valid(cap_valid[i])
    );
  end

endmodule

// File: tb/tb_pd_pluse_timer_mc.sv
// Bench for pd_pluse_timer_mc: three instances (16-bit saturating, 4-bit
// saturating, 4-bit wrapping) share the qualifiers and are checked against a
// window-length reference model through expected queues.
module tb_pd_pluse_timer_mc;

  localparam int NI = 3;
  localparam int CH = 4;

  // ---------------- clock / reset ----------------
  logic dds = 1'b0;
  logic rst = 1'b1;
  always #5 dds = ~dds;

  logic [CH-1:0] ps = '0;
  logic [CH-1:0] so = '0;
  logic [15:0]   th16 = '0;
  logic [3:0]    th4 = '0;

  logic [63:0] cnt0, cap0;
  logic [15:0] cnt1, cap1, cnt2, cap2;
  logic [CH-1:0] ovf0, hit0, cov0, cv0;
  logic [CH-1:0] ovf1, hit1, cov1, cv1;
  logic [CH-1:0] ovf2, hit2, cov2, cv2;

  pd_pluse_timer_mc #(.CH(CH), .WIDTH(16), .SAT_MODE(1)) dut_sat16 (
    .dds(dds), .rst(rst), .pluse_start(ps), .stateover(so), .thresh(th16),
    .count(cnt0), .ovf(ovf0), .hit(hit0), .cap(cap0), .cap_ovf(cov0), .cap_valid(cv0));

  pd_pluse_timer_mc #(.CH(CH), .WIDTH(4), .SAT_MODE(1)) dut_sat4 (
    .dds(dds), .rst(rst), .pluse_start(ps), .stateover(so), .thresh(th4),
    .count(cnt1), .ovf(ovf1), .hit(hit1), .cap(cap1), .cap_ovf(cov1), .cap_valid(cv1));

  pd_pluse_timer_mc #(.CH(CH), .WIDTH(4), .SAT_MODE(0)) dut_wrap4 (
    .dds(dds), .rst(rst), .pluse_start(ps), .stateover(so), .thresh(th4),
    .count(cnt2), .ovf(ovf2), .hit(hit2), .cap(cap2), .cap_ovf(cov2), .cap_valid(cv2));

  logic [15:0] act_cnt [NI][CH];
  logic [15:0] act_cap [NI][CH];
  logic        act_ovf [NI][CH];
  logic        act_hit [NI][CH];
  logic        act_cov [NI][CH];
  logic        act_cv  [NI][CH];

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      act_cnt[0][c] = cnt0[c*16 +: 16];
      act_cap[0][c] = cap0[c*16 +: 16];
      act_cnt[1][c] = {12'b0, cnt1[c*4 +: 4]};
      act_cap[1][c] = {12'b0, cap1[c*4 +: 4]};
      act_cnt[2][c] = {12'b0, cnt2[c*4 +: 4]};
      act_cap[2][c] = {12'b0, cap2[c*4 +: 4]};
      act_ovf[0][c] = ovf0[c]; act_hit[0][c] = hit0[c]; act_cov[0][c] = cov0[c]; act_cv[0][c] = cv0[c];
      act_ovf[1][c] = ovf1[c]; act_hit[1][c] = hit1[c]; act_cov[1][c] = cov1[c]; act_cv[1][c] = cv1[c];
      act_ovf[2][c] = ovf2[c]; act_hit[2][c] = hit2[c]; act_cov[2][c] = cov2[c]; act_cv[2][c] = cv2[c];
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [NI-1:0][CH-1:0][15:0] cnt;
    logic [NI-1:0][CH-1:0][15:0] cap;
    logic [NI-1:0][CH-1:0]       ovf;
    logic [NI-1:0][CH-1:0]       hit;
    logic [NI-1:0][CH-1:0]       cv;
    logic [NI-1:0][CH-1:0]       cov;
  } exp_t;

  typedef struct packed {
    logic [15:0] cap;
    logic        ovf;
  } cap_t;

  exp_t exp_q[$];
  cap_t cap_q[$];

  int          win_len   [NI][CH];
  logic        gate_prev [NI][CH];
  logic [15:0] last_cap  [NI][CH];
  logic        last_cov  [NI][CH];

  function automatic int width_of(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  // Visible count after k gated edges in the current window.
  function automatic int count_of(input int i, input int k);
    int span;
    span = 1 << width_of(i);
    if (i == 2) return k % span;
    return (k >= span) ? span - 1 : k;
  endfunction

  always @(posedge dds) begin
    exp_t e;
    cap_t ce;
    logic [CH-1:0] g;
    int maxv, th, k;
    logic h, v;
    e = '0;
    g = ps & so;
    for (int i = 0; i < NI; i++) begin
      maxv = (1 << width_of(i)) - 1;
      th = (i == 0) ? int'(th16) : int'(th4);
      for (int c = 0; c < CH; c++) begin
        h = 1'b0;
        v = 1'b0;
        k = win_len[i][c];
        if (rst) begin
          k = 0;
          gate_prev[i][c] = 1'b0;
          last_cap[i][c] = '0;
          last_cov[i][c] = 1'b0;
        end else begin
          if (g[c]) begin
            h = (th != 0) && (count_of(i, k + 1) == th) && !(i != 2 && k >= maxv);
            k = k + 1;
          end else begin
            if (gate_prev[i][c]) begin
              v = 1'b1;
              last_cap[i][c] = 16'(count_of(i, k));
              last_cov[i][c] = (k > maxv);
              ce.cap = last_cap[i][c];
              ce.ovf = last_cov[i][c];
              cap_q.push_back(ce);
            end
            k = 0;
          end
          gate_prev[i][c] = g[c];
        end
        win_len[i][c] = k;
        e.cnt[i][c] = 16'(count_of(i, k));
        e.ovf[i][c] = (k > maxv);
        e.hit[i][c] = h;
        e.cv[i][c]  = v;
        e.cap[i][c] = last_cap[i][c];
        e.cov[i][c] = last_cov[i][c];
      end
    end
    exp_q.push_back(e);
  end

  // ---------------- scoreboard / monitor ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int i, input int c, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d ch%0d t=%0t actual=%0d expected=%0d", nm, i, c, $time, act, exp);
    end
  endtask

  always @(posedge dds) begin
    exp_t e;
    cap_t ce;
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL exp_q_empty t=%0t actual=0 expected=1", $time);
    end else begin
      e = exp_q.pop_front();
      for (int i = 0; i < NI; i++) begin
        for (int c = 0; c < CH; c++) begin
          chk("count", i, c, int'(act_cnt[i][c]), int'(e.cnt[i][c]));
          chk("ovf", i, c, int'(act_ovf[i][c]), int'(e.ovf[i][c]));
          chk("hit", i, c, int'(act_hit[i][c]), int'(e.hit[i][c]));
          chk("cap_valid", i, c, int'(act_cv[i][c]), int'(e.cv[i][c]));
          chk("cap_hold", i, c, int'(act_cap[i][c]), int'(e.cap[i][c]));
          if (act_cv[i][c]) begin
            if (cap_q.size() == 0) begin
              chk("cap_unexpected", i, c, 1, 0);
            end else begin
              ce = cap_q.pop_front();
              chk("cap", i, c, int'(act_cap[i][c]), int'(ce.cap));
              chk("cap_ovf", i, c, int'(act_cov[i][c]), int'(ce.ovf));
            end
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step(input logic [CH-1:0] g, input logic r);
    int sel;
    @(negedge dds);
    rst = r;
    for (int c = 0; c < CH; c++) begin
      if (g[c]) begin
        ps[c] = 1'b1;
        so[c] = 1'b1;
      end else begin
        sel = $urandom_range(0, 2);
        ps[c] = (sel == 1);
        so[c] = (sel == 2);
      end
    end
  endtask

  task automatic windows(input int l0, l1, l2, l3, input int o0, o1, o2, o3);
    int tot;
    logic [CH-1:0] g;
    tot = 0;
    if (o0 + l0 > tot) tot = o0 + l0;
    if (o1 + l1 > tot) tot = o1 + l1;
    if (o2 + l2 > tot) tot = o2 + l2;
    if (o3 + l3 > tot) tot = o3 + l3;
    for (int t = 0; t < tot; t++) begin
      g[0] = (t >= o0) && (t < o0 + l0);
      g[1] = (t >= o1) && (t < o1 + l1);
      g[2] = (t >= o2) && (t < o2 + l2);
      g[3] = (t >= o3) && (t < o3 + l3);
      step(g, 1'b0);
    end
    step('0, 1'b0);
    step('0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [CH-1:0] rg;
    for (int i = 0; i < NI; i++)
      for (int c = 0; c < CH; c++) begin
        win_len[i][c] = 0; gate_prev[i][c] = 1'b0; last_cap[i][c] = '0; last_cov[i][c] = 1'b0;
      end

    // reset held with every gate high
    for (int n = 0; n < 3; n++) step('1, 1'b1);
    step('0, 1'b0);

    // single 5-edge window on ch0
    windows(5, 0, 0, 0, 0, 0, 0, 0);

    // threshold hit, then disabled threshold
    th16 = 16'd3; th4 = 4'd3;
    windows(0, 6, 0, 0, 0, 0, 0, 0);
    th16 = 16'd0; th4 = 4'd0;
    windows(0, 6, 0, 0, 0, 0, 0, 0);

    // long windows: saturate / wrap in the 4-bit instances
    th16 = 16'd2; th4 = 4'd2;
    windows(20, 18, 0, 0, 0, 0, 0, 0);
    th4 = 4'd15;
    windows(20, 0, 0, 0, 0, 0, 0, 0);

    // fall then rise after one low cycle
    for (int n = 0; n < 4; n++) step(4'b0001, 1'b0);
    step('0, 1'b0);
    for (int n = 0; n < 7; n++) step(4'b0001, 1'b0);
    step('0, 1'b0);
    // fall and rise on consecutive edges
    for (int n = 0; n < 3; n++) step(4'b0010, 1'b0);
    step('0, 1'b0);
    for (int n = 0; n < 2; n++) step(4'b0010, 1'b0);
    step('0, 1'b0);

    // all channels, ch2 falling together with ch0
    th16 = 16'd9; th4 = 4'd1;
    windows(2, 9, 1, 30, 0, 0, 1, 0);

    // reset in the middle of a ch3 window
    for (int n = 0; n < 10; n++) step(4'b1000, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    for (int n = 0; n < 6; n++) step(4'b1000, 1'b0);
    step(4'b1000, 1'b1);
    step(4'b1000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // randomized traffic
    rg = '0;
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 7) == 0) rg[c] = ~rg[c];
      if ($urandom_range(0, 15) == 0) begin
        th16 = 16'($urandom_range(0, 12));
        th4  = 4'($urandom_range(0, 15));
      end
      step(rg, ($urandom_range(0, 249) == 0));
    end
    step('0, 1'b0);
    step('0, 1'b0);
    step('0, 1'b0);

    checks++;
    if (cap_q.size() != 0) begin
      errors++;
      $display("FAIL cap_leftover actual=%0d expected=0", cap_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
